vector_exec_stage: RTL and testbench
====================================

Name: vector_exec_stage

Overview:
- Execute stage directly downstream of regFile. Consumes operand1/operand2 (vectorSize lanes × registerSize bits) plus a decoded op and destination.
- Performs lane-wise ALU ops: single-cycle logic/arithmetic and a multi-cycle iterative multiply.
- Produces a registered writeback bundle (data, regToWrite, scalar/vector write enables) that feeds regFile's write port.
- Uses a valid/ready handshake toward decode, so issue stalls while a multiply is in flight.

Parameters:
- registerSize, 8, bits per lane.
- vectorSize, 4, number of lanes.
- selectionBits, 2, register index width; destination field is selectionBits+1 bits (MSB = scalar bank).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- inValid  input  1  operation presented this cycle.
- inReady  output  1  stage can accept an operation.
- opCode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 MUL, 111 PASS.
- operand1  input  vectorSize×registerSize  lane operand A (packed [vectorSize-1:0][registerSize-1:0]).
- operand2  input  vectorSize×registerSize  lane operand B.
- inRegToWrite  input  selectionBits+1  destination register.
- inWrEnSc  input  1  result targets scalar bank.
- inWrEnVec  input  1  result targets vector bank.
- outValid  output  1  writeback bundle valid, one-cycle pulse.
- dataIn  output  vectorSize×registerSize  result to regFile dataIn.
- regToWrite  output  selectionBits+1  to regFile regToWrite.
- regWrEnSc  output  1  = outValid & latched inWrEnSc.
- regWrEnVec  output  1  = outValid & latched inWrEnVec.

Behaviour:
- Reset values:
  - state=IDLE, outValid=0, dataIn=0, regToWrite=0, regWrEnSc=0, regWrEnVec=0.
  - Internal counter, accumulator and multiplicand registers are 0.
  - inReady=1 in the cycle after reset is deasserted.
- Accept occurs on a rising edge with inValid&inReady. inReady=1 iff state==IDLE (combinational from state only; never depends on inValid).
- All ops are per lane, with the result truncated to registerSize bits (mod 2^registerSize):
  - ADD: a+b. SUB: a−b.
  - AND, OR, XOR: bitwise.
  - SLL: a << b[$clog2(registerSize)-1:0].
  - PASS: a.
  - MUL: low registerSize bits of a×b.
- Single-cycle ops (all except MUL):
  - Result, destination and enables are registered at the accept edge.
  - outValid=1 for exactly the following cycle.
  - State stays IDLE, so back-to-back accepts give outValid every cycle.
- MUL, FSM IDLE→MUL→IDLE:
  - At the accept edge: latch operands, destination and enables; counter=0; accumulator=0; state=MUL; outValid=0.
  - In MUL, each edge and for each lane: if multiplier bit0 is set, acc+=mcand; then mcand<<=1, mplier>>=1, counter++.
  - On the edge where counter==registerSize-1 (registerSize iterations done): dataIn=final acc, outValid=1, state=IDLE.
  - Accept-to-outValid latency is registerSize edges. inReady=0 for registerSize cycles.
  - An op accepted in the cycle outValid is high is legal (state already IDLE).
- Both enables set: both write strobes are asserted, and regFile decides. Neither set: outValid still pulses, and both strobes are 0.
- Scalar destination: all lanes are computed. regFile stores lane 0.
- outValid has no backpressure; regFile always consumes.
- Reset mid-MUL: the operation is aborted and no outValid is produced. All outputs return to reset values on that edge.
- inValid while inReady=0 is ignored (the upstream must hold).

Optional Feature:
- Macro SATURATE_EN.
- When defined: ADD and SUB are unsigned-saturating per lane (ADD clamps to 2^registerSize−1, SUB clamps to 0). All other ops are unchanged.
- When undefined: ADD and SUB wrap mod 2^registerSize as specified above.

Test Plan:
- ADD: reset 2 cycles, then issue ADD, operand1=32'h01020304, operand2=32'h01010101, inWrEnVec=1, inRegToWrite=3 → next cycle outValid=1, dataIn=32'h02030405, regToWrite=3, regWrEnVec=1, regWrEnSc=0; cycle after, outValid=0.
- SUB wrap: SUB with operand1=32'h00000010, operand2=32'h00000020 → lane0=8'hF0, other lanes 0. With SATURATE_EN: lane0=8'h00. ADD 8'hFF+8'h02 → 8'h01, or 8'hFF with SATURATE_EN.
- MUL: operand1=32'h03050710, operand2=32'h04030210, inWrEnSc=1, inRegToWrite=4 → inReady=0 for 8 cycles; outValid exactly 8 edges after accept; dataIn=32'h0C0F0E00; regWrEnSc=1.
- Back-to-back issue: inValid held for XOR, AND, SLL (operand2 lanes=1) on consecutive cycles → three consecutive outValid pulses with matching results. Then MUL followed by held ADD → ADD accepted in the cycle MUL's outValid is high, and its result appears one cycle later.
- Reset mid-MUL: issue MUL, assert reset 3 cycles later → outValid never asserts, all outputs 0, inReady=1 after reset drops.
- Regfile loop: stage outputs wired to regFile. Issue PASS operand1=4, inWrEnSc=1, inRegToWrite=0 → reading rSel=4 gives 32'h04040404; vector register 0 still reads 0.

Source files
------------

// File: rtl/vector_exec_stage.sv
// -----------------------------------------------------------------------------
// vector_exec_stage
//
// Purpose:
//   Execute stage that sits between regFile read and regFile write. It takes
//   two lane-packed operands plus a decoded op and destination, computes a
//   lane-wise result and presents it as a registered writeback bundle.
//   Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, PASS) produce their result
//   on the edge they are accepted. MUL runs a shift-and-add multiplier for
//   registerSize iterations, during which the stage refuses new work.
//
// Configuration:
//   SATURATE_EN  when defined, ADD and SUB saturate per lane (unsigned).
//                When undefined, ADD and SUB wrap modulo 2^registerSize.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         synchronous active-high reset
//   inValid       operation presented this cycle
//   inReady       stage can accept an operation (state only, never inValid)
//   opCode        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL,
//                 110 MUL, 111 PASS
//   operand1      lane operand A, [vectorSize-1:0][registerSize-1:0]
//   operand2      lane operand B
//   inRegToWrite  destination register (MSB selects the scalar bank)
//   inWrEnSc      result targets the scalar bank
//   inWrEnVec     result targets the vector bank
//   outValid      writeback bundle valid, one-cycle pulse
//   dataIn        result bundle to regFile
//   regToWrite    destination register to regFile
//   regWrEnSc     outValid qualified scalar write strobe
//   regWrEnVec    outValid qualified vector write strobe
// -----------------------------------------------------------------------------
module vector_exec_stage #(
  parameter int registerSize  = 8,
  parameter int vectorSize    = 4,
  parameter int selectionBits = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      inValid,
  output logic                                      inReady,
  input  logic [2:0]                                opCode,
  input  logic [vectorSize-1:0][registerSize-1:0]   operand1,
  input  logic [vectorSize-1:0][registerSize-1:0]   operand2,
  input  logic [selectionBits:0]                    inRegToWrite,
  input  logic                                      inWrEnSc,
  input  logic                                      inWrEnVec,
  output logic                                      outValid,
  output logic [vectorSize-1:0][registerSize-1:0]   dataIn,
  output logic [selectionBits:0]                    regToWrite,
  output logic                                      regWrEnSc,
  output logic                                      regWrEnVec
);

  localparam int ShW  = (registerSize > 1) ? $clog2(registerSize) : 1;
  localparam int CntW = ShW;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // State and datapath registers
  logic [0:0]                                state_q,  state_d;
  logic [CntW-1:0]                           cnt_q,    cnt_d;
  logic [vectorSize-1:0][registerSize-1:0]   acc_q,    acc_d;
  logic [vectorSize-1:0][registerSize-1:0]   mcand_q,  mcand_d;
  logic [vectorSize-1:0][registerSize-1:0]   mplier_q, mplier_d;
  logic                                      valid_q,  valid_d;
  logic [vectorSize-1:0][registerSize-1:0]   data_q,   data_d;
  logic [selectionBits:0]                    reg_q,    reg_d;
  logic                                      en_sc_q,  en_sc_d;
  logic                                      en_vec_q, en_vec_d;

  // Per-lane combinational results
  logic [vectorSize-1:0][registerSize-1:0]   alu_res;
  logic [vectorSize-1:0][registerSize-1:0]   acc_step;
  logic [vectorSize-1:0][registerSize-1:0]   mcand_sh;
  logic [vectorSize-1:0][registerSize-1:0]   mplier_sh;

  genvar gi;
  generate
    for (gi = 0; gi < vectorSize; gi++) begin : g_lane
      logic [registerSize-1:0] add_w;
      logic [registerSize-1:0] sub_w;
      logic [registerSize-1:0] lane_res;

`ifdef SATURATE_EN
      // One extra bit catches the carry (ADD overflow) or borrow (SUB underflow).
      logic [registerSize:0] sum_w;
      logic [registerSize:0] diff_w;
      assign sum_w  = {1'b0, operand1[gi]} + {1'b0, operand2[gi]};
      assign diff_w = {1'b0, operand1[gi]} - {1'b0, operand2[gi]};
      assign add_w  = sum_w[registerSize]  ? '1 : sum_w[registerSize-1:0];
      assign sub_w  = diff_w[registerSize] ? '0 : diff_w[registerSize-1:0];
`else
      assign add_w  = operand1[gi] + operand2[gi];
      assign sub_w  = operand1[gi] - operand2[gi];
`endif

      always_comb begin
        lane_res = operand1[gi];
        case (opCode)
          OP_ADD:  lane_res = add_w;
          OP_SUB:  lane_res = sub_w;
          OP_AND:  lane_res = operand1[gi] & operand2[gi];
          OP_OR:   lane_res = operand1[gi] | operand2[gi];
          OP_XOR:  lane_res = operand1[gi] ^ operand2[gi];
          OP_SLL:  lane_res = operand1[gi] << operand2[gi][ShW-1:0];
          default: lane_res = operand1[gi];  // PASS; MUL never uses this path
        endcase
      end

      assign alu_res[gi]   = lane_res;
      // One shift-and-add iteration: add the multiplicand when the current
      // multiplier LSB is set, then walk both operands by one bit.
      assign acc_step[gi]  = acc_q[gi] + (mplier_q[gi][0] ? mcand_q[gi] : '0);
      assign mcand_sh[gi]  = mcand_q[gi] << 1;
      assign mplier_sh[gi] = mplier_q[gi] >> 1;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    reg_d    = reg_q;
    en_sc_d  = en_sc_q;
    en_vec_d = en_vec_q;

    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          reg_d    = inRegToWrite;
          en_sc_d  = inWrEnSc;
          en_vec_d = inWrEnVec;
          if (opCode == OP_MUL) begin
            state_d  = ST_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = operand1;
            mplier_d = operand2;
          end else begin
            data_d  = alu_res;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        acc_d    = acc_step;
        mcand_d  = mcand_sh;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q + 1'b1;
        // Last iteration: publish the accumulator including this edge's add.
        if (cnt_q == CntW'(registerSize - 1)) begin
          data_d  = acc_step;
          valid_d = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      reg_q    <= '0;
      en_sc_q  <= 1'b0;
      en_vec_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      reg_q    <= reg_d;
      en_sc_q  <= en_sc_d;
      en_vec_q <= en_vec_d;
    end
  end

  assign inReady    = (state_q == ST_IDLE);
  assign outValid   = valid_q;
  assign dataIn     = data_q;
  assign regToWrite = reg_q;
  assign regWrEnSc  = valid_q & en_sc_q;
  assign regWrEnVec = valid_q & en_vec_q;

endmodule

// File: tb/tb_vector_exec_stage.sv
module tb_vector_exec_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  opCode = 3'd0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [2:0]  inRegToWrite = '0;
  logic        inWrEnSc = 1'b0;
  logic        inWrEnVec = 1'b0;
  logic        outValid;
  logic [31:0] dataIn;
  logic [2:0]  regToWrite;
  logic        regWrEnSc;
  logic        regWrEnVec;

  vector_exec_stage #(.registerSize(8), .vectorSize(4), .selectionBits(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .opCode       (opCode),
    .operand1     (operand1),
    .operand2     (operand2),
    .inRegToWrite (inRegToWrite),
    .inWrEnSc     (inWrEnSc),
    .inWrEnVec    (inWrEnVec),
    .outValid     (outValid),
    .dataIn       (dataIn),
    .regToWrite   (regToWrite),
    .regWrEnSc    (regWrEnSc),
    .regWrEnVec   (regWrEnVec)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLL = 3'd5, MUL = 3'd6, PASS = 3'd7;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Behavioural model: lane-wise integer arithmetic, truncated to 8 bits.
  function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      int x, y, r;
      x = int'(a[8*l +: 8]);
      y = int'(b[8*l +: 8]);
      case (op)
`ifdef SATURATE_EN
        ADD:  r = (x + y > 255) ? 255 : x + y;
        SUB:  r = (x - y < 0) ? 0 : x - y;
`else
        ADD:  r = x + y;
        SUB:  r = x - y;
`endif
        AND_: r = x & y;
        OR_:  r = x | y;
        XOR_: r = x ^ y;
        SLL:  r = x << (y % 8);
        MUL:  r = x * y;
        default: r = x;
      endcase
      res[8*l +: 8] = r[7:0];
    end
    return res;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [2:0]  rg;
    logic        sc;
    logic        vec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;         // number of rising edges seen
  int   ready_from = 0;  // first cycle in which the stage may accept again
  int   acc_cnt = 0;     // accepted operations according to the model
  bit   started = 0;
  bit   rst_edge = 0;
  logic [31:0] last_data = '0;
  logic [2:0]  last_reg = '0;

  // Model: decides acceptance from its own notion of readiness and schedules
  // the expected writeback (1 cycle for ALU ops, 8 cycles for MUL).
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      ready_from = cyc;
      started = 1;
      rst_edge = 1;
    end else begin
      rst_edge = 0;
      if (started && inValid && (cyc - 1) >= ready_from) begin
        acc_cnt++;
        e.data = model_op(opCode, operand1, operand2);
        e.rg   = inRegToWrite;
        e.sc   = inWrEnSc;
        e.vec  = inWrEnVec;
        if (opCode == MUL) begin
          e.due = cyc + 8;
          ready_from = cyc + 8;
        end else begin
          e.due = cyc;
        end
        q.push_back(e);
      end
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    bit exp_v;
    if (started) begin
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      exp_v = (q.size() > 0 && q[0].due == cyc);
      chk("inReady", {31'd0, inReady}, {31'd0, (cyc >= ready_from)});
      chk("outValid", {31'd0, outValid}, {31'd0, exp_v});
      if (exp_v) begin
        chk("dataIn", dataIn, q[0].data);
        chk("regToWrite", {29'd0, regToWrite}, {29'd0, q[0].rg});
        chk("regWrEnSc", {31'd0, regWrEnSc}, {31'd0, q[0].sc});
        chk("regWrEnVec", {31'd0, regWrEnVec}, {31'd0, q[0].vec});
        $display("txn cyc=%0d data=%08h reg=%0d sc=%0b vec=%0b",
                 cyc, dataIn, regToWrite, regWrEnSc, regWrEnVec);
        last_data = dataIn;
        last_reg  = regToWrite;
        void'(q.pop_front());
      end else begin
        chk("idle_strobes", {30'd0, regWrEnSc, regWrEnVec}, 32'd0);
      end
      if (rst_edge) begin
        chk("reset_dataIn", dataIn, 32'd0);
        chk("reset_regToWrite", {29'd0, regToWrite}, 32'd0);
      end
    end
  end

  // Present an op and hold it until the model says it was accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rg, input logic sc, input logic vec);
    int start;
    int n;
    start = acc_cnt;
    n = 0;
    opCode = op; operand1 = a; operand2 = b;
    inRegToWrite = rg; inWrEnSc = sc; inWrEnVec = vec;
    inValid = 1'b1;
    while (acc_cnt == start && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (acc_cnt == start) begin
      n_bad++;
      $display("FAIL issue_timeout: got %0d accepts expected %0d", acc_cnt, start + 1);
    end
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ADD into vector reg 3
    issue(ADD, 32'h01020304, 32'h01010101, 3'd3, 1'b0, 1'b1);
    idle(2);
    chk("lit_add", last_data, 32'h02030405);
    chk("lit_add_reg", {29'd0, last_reg}, 32'd3);

    // SUB wrap / saturate
    issue(SUB, 32'h00000010, 32'h00000020, 3'd1, 1'b0, 1'b1);
    idle(1);
`ifdef SATURATE_EN
    chk("lit_sub", last_data, 32'h00000000);
`else
    chk("lit_sub", last_data, 32'h000000F0);
`endif

    // ADD overflow
    issue(ADD, 32'h000000FF, 32'h00000002, 3'd2, 1'b0, 1'b1);
    idle(1);
`ifdef SATURATE_EN
    chk("lit_add_ovf", last_data, 32'h000000FF);
`else
    chk("lit_add_ovf", last_data, 32'h00000001);
`endif

    // MUL into scalar reg 4
    issue(MUL, 32'h03050710, 32'h04030210, 3'd4, 1'b1, 1'b0);
    idle(10);
    chk("lit_mul", last_data, 32'h0C0F0E00);
    chk("lit_mul_reg", {29'd0, last_reg}, 32'd4);

    // MUL with large lanes
    issue(MUL, 32'hFFFF0102, 32'hFF01807F, 3'd5, 1'b0, 1'b1);
    idle(10);
    chk("lit_mul2", last_data, 32'h01FF80FE);

    // Back-to-back single-cycle ops
    issue(XOR_, 32'h8142F00F, 32'h01010101, 3'd0, 1'b0, 1'b1);
    issue(AND_, 32'h8142F00F, 32'h01010101, 3'd1, 1'b0, 1'b1);
    issue(SLL,  32'h8142F00F, 32'h01010101, 3'd2, 1'b0, 1'b1);
    idle(2);
    chk("lit_sll", last_data, 32'h0284E01E);

    // MUL followed by a held ADD, accepted in MUL's outValid cycle
    issue(MUL, 32'h02020202, 32'h03030303, 3'd1, 1'b0, 1'b1);
    issue(ADD, 32'h10203040, 32'h01020304, 3'd2, 1'b0, 1'b1);
    idle(2);
    chk("lit_add_after_mul", last_data, 32'h11223344);

    // Both enables, then neither enable
    issue(OR_, 32'hF0F00000, 32'h0F000F00, 3'd6, 1'b1, 1'b1);
    issue(PASS, 32'hDEADBEEF, 32'h0, 3'd7, 1'b0, 1'b0);
    idle(2);
    chk("lit_pass_none", last_data, 32'hDEADBEEF);

    // Reset in the middle of a MUL
    issue(MUL, 32'h05050505, 32'h05050505, 3'd3, 1'b1, 1'b0);
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(12);

    // PASS into scalar reg 0
    issue(PASS, 32'h00000004, 32'h0, 3'd0, 1'b1, 1'b0);
    idle(2);
    chk("lit_pass", last_data, 32'h00000004);
    chk("lit_pass_reg", {29'd0, last_reg}, 32'd0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
